gb_irq_ctrl: RTL and testbench
==============================

Name: gb_irq_ctrl

Overview:
Interrupt controller directly upstream of the CPU core. It holds the IF (0xFF0F) and IE (0xFFFF) registers and the master enable IME, and latches peripheral requests. It tells the core when an interrupt must be taken and sequences the 5 M-cycle dispatch, supplying the stage and the final jump vector. It snoops the CPU bus for register reads and writes, so it can see IE writes made by the dispatch stack push.

Parameters:
NUM_IRQ, 5, number of request lines (bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad)
IF_ADDR, 16'hFF0F, IF register address
IE_ADDR, 16'hFFFF, IE register address
VECTOR_BASE, 16'h0040, vector of bit0
VECTOR_STRIDE, 8, vector spacing per bit

Ports:
clk  input  1  machine (M) clock; all state on posedge
reset  input  1  asynchronous, active-low reset
addr_i  input  16  CPU address bus
data_i  input  8  CPU outgoing data bus
wr_en_i  input  1  CPU drive_data_bus (write strobe)
rd_data_o  output  8  read data for IF/IE
rd_hit_o  output  1  addr_i matches IF_ADDR or IE_ADDR (read-mux select)
irq_req_i  input  NUM_IRQ  peripheral request levels
ime_set_i  input  1  EI taking effect (the core already applies the one-instruction delay)
ime_clr_i  input  1  DI
reti_i  input  1  RETI: set IME immediately
dispatch_start_i  input  1  core is at an instruction boundary and accepts the dispatch
irq_pending_o  output  1  |(IF & IE), ignores IME; HALT wake
irq_take_o  output  1  irq_pending_o & IME & state==IDLE
ime_o  output  1  current IME
dispatch_busy_o  output  1  state != IDLE
dispatch_stage_o  output  3  0 IDLE, 1 WAIT1, 2 WAIT2, 3 PUSH_HI, 4 PUSH_LO, 5 JUMP
vector_o  output  16  jump target; valid when vector_valid_o
vector_valid_o  output  1  high in PUSH_LO and JUMP

Behaviour:
- Reset values: IF=0, IE=0, IME=0, edge register=0, state IDLE, vector_o=0, all outputs low except rd_data_o (combinational).
- Request edge detect: the previous irq_req_i is registered. A rising edge sets the matching IF bit on the next edge.
- Register writes: wr_en_i with addr_i==IF_ADDR writes IF[NUM_IRQ-1:0]. With addr_i==IE_ADDR it writes all 8 IE bits.
- Same-cycle IF write and request edge: the write applies first, then the set is ORed in, so the request wins.
- Register reads (combinational): IF reads {3'b111, IF[4:0]}; IE reads the full 8 bits. rd_data_o=0 when there is no hit.
- IME update priority within a cycle: dispatch_start accepted (clear) > ime_clr_i > ime_set_i | reti_i.
- dispatch_start_i is accepted only when irq_take_o=1. Otherwise it is ignored.
- FSM: IDLE -(start accepted)-> WAIT1 -> WAIT2 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE, one M-cycle per state, no stalls.
- IME is cleared on the accepting edge.
- Vector resolution happens on the clock edge that ends PUSH_HI:
  - Evaluate IF & IE after any bus write made in that cycle (including an IE write by the push).
  - Select the lowest set bit n.
  - vector_o = VECTOR_BASE + n*VECTOR_STRIDE.
  - Clear IF[n] on that same edge.
  - If nothing is pending, vector_o = 16'h0000 and IF is unchanged (cancel).
- vector_o holds its value until the next resolution.
- Requests and register writes keep working during dispatch.
- Async reset mid-dispatch returns to IDLE immediately with all registers cleared.

Optional Feature:
GB_IRQ_IE_CANCEL_EN
- Defined: late-resolution behaviour exactly as above, including the 16'h0000 cancel vector.
- Undefined: the vector and the IF bit to clear are latched on the accepting edge (lowest bit of IF & IE at that time). IF[n] is cleared on the edge ending PUSH_HI regardless of later IE/IF writes. No cancel path: the vector is never 0x0000.

Test Plan:
- Reset low mid-PUSH_LO, then release -> stage 0, IF=0, IE=0, IME=0, IF read=0xE0, vector_valid_o=0.
- Rising edge on irq_req_i[2] held 3 cycles -> IF read 0xE4 after 1 edge. No further set after software writes IF=0 while the line stays high.
- IE=0x05, IME=1, edges on bits 0 and 2, dispatch_start -> stages 1..5 on consecutive cycles, vector_o=0x0040 in PUSH_LO, IF=0xE4 afterwards, IME=0.
- Macro defined: IE=0x01, IF bit0 set, dispatch; IE write 0x00 during PUSH_HI -> vector 0x0000, IF stays 0xE1. Macro undefined, same stimulus -> vector 0x0040, IF=0xE0.
- IME=0, IE=0x10, joypad edge -> irq_pending_o=1, irq_take_o=0; dispatch_start_i ignored, stage stays 0.
- Same cycle: write IF=0x00 and irq_req_i[4] rising edge -> IF read 0xF0.

Source files
------------

// File: rtl/gb_irq_ctrl.sv
// Game Boy interrupt controller: IF/IE/IME state and 5 M-cycle dispatch sequencer.
// Define GB_IRQ_IE_CANCEL_EN to resolve the vector late (end of PUSH_HI) with cancel.
module gb_irq_ctrl #(
    parameter int          NUM_IRQ       = 5,
    parameter logic [15:0] IF_ADDR       = 16'hFF0F,
    parameter logic [15:0] IE_ADDR       = 16'hFFFF,
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int          VECTOR_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr_i,
    input  logic [7:0]         data_i,
    input  logic               wr_en_i,
    output logic [7:0]         rd_data_o,
    output logic               rd_hit_o,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic               ime_set_i,
    input  logic               ime_clr_i,
    input  logic               reti_i,
    input  logic               dispatch_start_i,
    output logic               irq_pending_o,
    output logic               irq_take_o,
    output logic               ime_o,
    output logic               dispatch_busy_o,
    output logic [2:0]         dispatch_stage_o,
    output logic [15:0]        vector_o,
    output logic               vector_valid_o
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT1   = 3'd1,
        WAIT2   = 3'd2,
        PUSH_HI = 3'd3,
        PUSH_LO = 3'd4,
        JUMP    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] if_q, req_q, if_wr, rise, clr_mask, src;
    logic [7:0]         ie_q, ie_wr;
    logic               ime_q, ime_d;
    logic [15:0]        vec_d;
    logic               if_sel, ie_sel, accept;
    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;

    function automatic logic [15:0] vec_of(input logic [IDX_W-1:0] n);
        return VECTOR_BASE + 16'(n) * 16'(VECTOR_STRIDE);
    endfunction

    assign if_sel = (addr_i == IF_ADDR);
    assign ie_sel = (addr_i == IE_ADDR);
    assign if_wr  = (wr_en_i && if_sel) ? data_i[NUM_IRQ-1:0] : if_q;
    assign ie_wr  = (wr_en_i && ie_sel) ? data_i : ie_q;
    assign rise   = irq_req_i & ~req_q;
    assign accept = dispatch_start_i & irq_take_o;

    assign irq_pending_o = |(if_q & ie_q[NUM_IRQ-1:0]);
    assign ime_o         = ime_q;
    assign rd_hit_o      = if_sel | ie_sel;

    always_comb begin
        rd_data_o = 8'h00;
        if (if_sel)
            rd_data_o = {{(8 - NUM_IRQ){1'b1}}, if_q};
        else if (ie_sel)
            rd_data_o = ie_q;
    end

    // Late mode sees this cycle's bus writes; early mode snapshots at accept.
`ifdef GB_IRQ_IE_CANCEL_EN
    assign src = if_wr & ie_wr[NUM_IRQ-1:0];
`else
    assign src = if_q & ie_q[NUM_IRQ-1:0];
    logic [IDX_W-1:0] lat_idx_q;
`endif

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (src[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        vec_d    = vector_o;
        if (state_q == PUSH_HI) begin
`ifdef GB_IRQ_IE_CANCEL_EN
            if (hit_any) begin
                clr_mask[hit_idx] = 1'b1;
                vec_d = vec_of(hit_idx);
            end else begin
                vec_d = 16'h0000;
            end
`else
            clr_mask[lat_idx_q] = 1'b1;
            vec_d = vec_of(lat_idx_q);
`endif
        end
    end

    always_comb begin
        ime_d = ime_q;
        if (accept)
            ime_d = 1'b0;
        else if (ime_clr_i)
            ime_d = 1'b0;
        else if (ime_set_i || reti_i)
            ime_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= '0;
            if_q     <= '0;
            ie_q     <= 8'h00;
            ime_q    <= 1'b0;
            vector_o <= 16'h0000;
        end else begin
            req_q    <= irq_req_i;
            if_q     <= (if_wr & ~clr_mask) | rise;
            ie_q     <= ie_wr;
            ime_q    <= ime_d;
            vector_o <= vec_d;
        end
    end

`ifndef GB_IRQ_IE_CANCEL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lat_idx_q <= '0;
        else if (accept && hit_any)
            lat_idx_q <= hit_idx;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? WAIT1 : IDLE;
            WAIT1:   state_d = WAIT2;
            WAIT2:   state_d = PUSH_HI;
            PUSH_HI: state_d = PUSH_LO;
            PUSH_LO: state_d = JUMP;
            JUMP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_take_o       = irq_pending_o & ime_q & (state_q == IDLE);
        dispatch_busy_o  = (state_q != IDLE);
        dispatch_stage_o = state_q;
        vector_valid_o   = (state_q == PUSH_LO) || (state_q == JUMP);
    end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Scoreboard bench for gb_irq_ctrl: directed test-plan sequences then random traffic
// against a cycle-level behavioural model of the interrupt rules.
module tb_gb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_i;
    logic [7:0]  data_i;
    logic        wr_en_i;
    logic [7:0]  rd_data_o;
    logic        rd_hit_o;
    logic [4:0]  irq_req_i;
    logic        ime_set_i, ime_clr_i, reti_i, dispatch_start_i;
    logic        irq_pending_o, irq_take_o, ime_o, dispatch_busy_o;
    logic [2:0]  dispatch_stage_o;
    logic [15:0] vector_o;
    logic        vector_valid_o;

    gb_irq_ctrl dut (
        .clk(clk), .reset(reset), .addr_i(addr_i), .data_i(data_i),
        .wr_en_i(wr_en_i), .rd_data_o(rd_data_o), .rd_hit_o(rd_hit_o),
        .irq_req_i(irq_req_i), .ime_set_i(ime_set_i), .ime_clr_i(ime_clr_i),
        .reti_i(reti_i), .dispatch_start_i(dispatch_start_i),
        .irq_pending_o(irq_pending_o), .irq_take_o(irq_take_o), .ime_o(ime_o),
        .dispatch_busy_o(dispatch_busy_o), .dispatch_stage_o(dispatch_stage_o),
        .vector_o(vector_o), .vector_valid_o(vector_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stage;
        logic        ime, pend, take, busy, vvalid, hit;
        logic [15:0] vec;
        logic [7:0]  rd;
    } snap_t;

    snap_t       sq[$];
    logic [15:0] vq[$];
    int          checks = 0;
    int          errors = 0;

    // behavioural model state
    int          stg = 0;
    int          latn = 0;
    logic [4:0]  ifm = 0, prevm = 0;
    logic [7:0]  iem = 0;
    logic        imem = 0;
    logic [15:0] vm = 0;
    logic [4:0]  cur = 0;

    function automatic int lowest(input logic [4:0] v);
        int r = -1;
        for (int i = 4; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rs, input logic [15:0] a, input logic [7:0] d,
                       input logic w, input logic [4:0] rq, input logic s,
                       input logic c, input logic r, input logic st);
        snap_t      e;
        logic [4:0] ifw, rise, clr;
        logic [7:0] iew;
        logic       pend, acc;
        int         n;
        @(negedge clk);
        reset = rs; addr_i = a; data_i = d; wr_en_i = w; irq_req_i = rq;
        ime_set_i = s; ime_clr_i = c; reti_i = r; dispatch_start_i = st;
        if (!rs) begin
            stg = 0; latn = 0; ifm = 0; prevm = 0; iem = 0; imem = 0; vm = 0;
        end else begin
            ifw  = (w && a == 16'hFF0F) ? d[4:0] : ifm;
            iew  = (w && a == 16'hFFFF) ? d : iem;
            rise = rq & ~prevm;
            pend = |(ifm & iem[4:0]);
            acc  = st && pend && imem && stg == 0;
            clr  = 5'b0;
            if (stg == 3) begin
`ifdef GB_IRQ_IE_CANCEL_EN
                n = lowest(ifw & iew[4:0]);
`else
                n = latn;
`endif
                if (n < 0) vm = 16'h0000;
                else begin
                    vm = 16'h0040 + 16'(8 * n);
                    clr[n] = 1'b1;
                end
                vq.push_back(vm);
            end
            if (acc) latn = lowest(ifm & iem[4:0]);
            ifm = (ifw & ~clr) | rise;
            iem = iew;
            prevm = rq;
            if (acc || c) imem = 1'b0;
            else if (s || r) imem = 1'b1;
            if (acc) stg = 1;
            else if (stg == 0 || stg == 5) stg = 0;
            else stg = stg + 1;
        end
        e.stage  = stg;
        e.ime    = imem;
        e.pend   = |(ifm & iem[4:0]);
        e.take   = e.pend && imem && stg == 0;
        e.busy   = stg != 0;
        e.vvalid = stg == 4 || stg == 5;
        e.vec    = vm;
        e.hit    = a == 16'hFF0F || a == 16'hFFFF;
        e.rd     = a == 16'hFF0F ? {3'b111, ifm} : a == 16'hFFFF ? iem : 8'h00;
        sq.push_back(e);
    endtask

    task automatic idle(input int k, input logic [15:0] a);
        for (int i = 0; i < k; i++) cyc(1, a, 8'h00, 0, cur, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1, a, d, 1, cur, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("stage", 32'(dispatch_stage_o), 32'(e.stage));
                chk("ime", 32'(ime_o), 32'(e.ime));
                chk("pending", 32'(irq_pending_o), 32'(e.pend));
                chk("take", 32'(irq_take_o), 32'(e.take));
                chk("busy", 32'(dispatch_busy_o), 32'(e.busy));
                chk("vvalid", 32'(vector_valid_o), 32'(e.vvalid));
                chk("vector", 32'(vector_o), 32'(e.vec));
                chk("rd_hit", 32'(rd_hit_o), 32'(e.hit));
                chk("rd_data", 32'(rd_data_o), 32'(e.rd));
            end
            if (dispatch_stage_o == 3'd4 && vector_valid_o) begin
                if (vq.size() == 0) chk("vec_q_empty", 32'(vector_o), 32'hFFFF_FFFF);
                else chk("vec_q", 32'(vector_o), 32'(vq.pop_front()));
            end
        end
    end

    initial begin
        logic [15:0] a;
        reset = 0; addr_i = 0; data_i = 0; wr_en_i = 0; irq_req_i = 0;
        ime_set_i = 0; ime_clr_i = 0; reti_i = 0; dispatch_start_i = 0;
        cyc(0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        // request edge on bit 2 held, then software clear while high
        cur = 5'b00100;
        idle(3, 16'hFF0F);
        wr(16'hFF0F, 8'h00);
        idle(2, 16'hFF0F);
        cur = 5'b00000;
        idle(1, 16'hFF0F);
        // full dispatch, bits 0 and 2 pending
        wr(16'hFFFF, 8'h05);
        cyc(1, 16'hFF0F, 0, 0, cur, 1, 0, 0, 0);
        cur = 5'b00101;
        idle(2, 16'hFF0F);
        cyc(1, 16'hFF0F, 0, 0, cur, 0, 0, 0, 1);
        idle(6, 16'hFF0F);
        // IE cleared during PUSH_HI
        wr(16'hFFFF, 8'h01);
        cyc(1, 16'hFF0F, 8'h01, 1, cur, 1, 0, 0, 0);
        cyc(1, 16'hFF0F, 0, 0, cur, 0, 0, 0, 1);
        idle(2, 16'hFF0F);
        wr(16'hFFFF, 8'h00);
        idle(4, 16'hFF0F);
        // IME off: pending but not taken
        cyc(1, 16'hFF0F, 0, 0, cur, 0, 1, 0, 0);
        wr(16'hFFFF, 8'h10);
        cur = 5'b10101;
        idle(1, 16'hFF0F);
        cyc(1, 16'hFF0F, 0, 0, cur, 0, 0, 0, 1);
        idle(1, 16'hFF0F);
        // IF write and request edge in the same cycle
        cur = 5'b00000;
        idle(1, 16'hFF0F);
        cur = 5'b10000;
        wr(16'hFF0F, 8'h00);
        idle(1, 16'hFF0F);
        // reset in PUSH_LO
        wr(16'hFFFF, 8'h1F);
        cyc(1, 16'hFF0F, 0, 0, cur, 1, 0, 0, 0);
        cyc(1, 16'hFF0F, 0, 0, cur, 0, 0, 0, 1);
        idle(3, 16'hFF0F);
        cyc(0, 16'hFF0F, 0, 0, cur, 0, 0, 0, 0);
        idle(2, 16'hFF0F);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'hFF0F;
                1: a = 16'hFFFF;
                2: a = 16'($urandom);
                default: a = 16'hFF0F;
            endcase
            if ($urandom_range(0, 5) == 0) cur = cur ^ 5'($urandom);
            cyc($urandom_range(0, 299) != 0, a, 8'($urandom),
                $urandom_range(0, 7) == 0, cur,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 0);
        end
        idle(2, 16'hFF0F);
        @(posedge clk);
        #2;
        chk("sq_drained", 32'(sq.size()), 32'd0);
        chk("vq_drained", 32'(vq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
